// File: rtl/alu_seq_wide.sv
// Multi-byte sequencer for the 8-bit ALU: accepts one wide command, executes it
// one byte per cycle LSB first with carry chaining, and returns the wide result and flags.
module alu_seq_wide #(
    parameter int NBYTES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic                cmd_cin,
    input  logic [8*NBYTES-1:0] cmd_a,
    input  logic [8*NBYTES-1:0] cmd_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [8*NBYTES-1:0] rsp_result,
    output logic                rsp_carry,
    output logic                rsp_overflow,
    output logic                rsp_zero,
    output logic                alu_en,
    output logic                alu_i3,
    output logic                alu_i4,
    output logic                alu_i5,
    output logic                alu_c_in,
    output logic [7:0]          alu_r,
    output logic [7:0]          alu_s,
    input  logic [7:0]          alu_f,
    input  logic                alu_zero,
    input  logic                alu_c_out,
    input  logic                alu_overflow
);

    localparam int W = 8 * NBYTES;
    localparam logic [1:0] LAST = 2'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t         state;
    logic [1:0]     k;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           zacc;

    // Constant-indexed byte pick so every part-select stays in range for any NBYTES.
    function automatic logic [7:0] byte_sel(input logic [W-1:0] v, input logic [1:0] idx);
        byte_sel = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx == 2'(i)) byte_sel = v[8*i +: 8];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            k            <= '0;
            a_q          <= '0;
            b_q          <= '0;
            zacc         <= 1'b1;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            alu_en       <= 1'b0;
            alu_i3       <= 1'b0;
            alu_i4       <= 1'b0;
            alu_i5       <= 1'b0;
            alu_c_in     <= 1'b0;
            alu_r        <= '0;
            alu_s        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_q       <= cmd_a;
                        b_q       <= cmd_b;
                        k         <= '0;
                        zacc      <= 1'b1;
                        alu_i3    <= cmd_op[0];
                        alu_i4    <= cmd_op[1];
                        alu_i5    <= cmd_op[2];
                        // Byte 0 operands are presented in the first EXEC cycle directly.
                        alu_en    <= 1'b1;
                        alu_r     <= cmd_a[7:0];
                        alu_s     <= cmd_b[7:0];
                        alu_c_in  <= cmd_cin;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    for (int unsigned i = 0; i < NBYTES; i++) begin
                        if (k == 2'(i)) rsp_result[8*i +: 8] <= alu_f;
                    end
                    zacc <= zacc & alu_zero;
                    if (k == LAST) begin
                        alu_en       <= 1'b0;
                        alu_r        <= '0;
                        alu_s        <= '0;
                        alu_c_in     <= 1'b0;
                        rsp_carry    <= alu_c_out;
                        rsp_overflow <= alu_overflow;
                        rsp_zero     <= zacc & alu_zero;
                        rsp_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        k        <= k + 2'd1;
                        alu_r    <= byte_sel(a_q, k + 2'd1);
                        alu_s    <= byte_sel(b_q, k + 2'd1);
                        alu_c_in <= alu_c_out;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_wide.sv
// Bench for alu_seq_wide: byte-level ALU model drives the DUT bus, wide-arithmetic
// reference model predicts results; NBYTES=2 and NBYTES=1 instances.
module tb_alu_seq_wide;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte ALU: 0 add, 1 add ~s (subtract), 2 and, 3 or, 4 xor, 5 pass r, 6 pass s, 7 not r.
    function automatic logic [10:0] alu_byte(input logic [2:0] op, input logic [7:0] r,
                                             input logic [7:0] s, input logic ci);
        logic [8:0] t;
        logic [7:0] f, sv;
        logic c, v;
        c = 1'b0; v = 1'b0; t = '0;
        sv = (op == 3'd1) ? ~s : s;
        case (op)
            3'd0, 3'd1: begin
                t = {1'b0, r} + {1'b0, sv} + {8'd0, ci};
                f = t[7:0];
                c = t[8];
                v = (r[7] == sv[7]) && (f[7] != r[7]);
            end
            3'd2: f = r & s;
            3'd3: f = r | s;
            3'd4: f = r ^ s;
            3'd5: f = r;
            3'd6: f = s;
            default: f = ~r;
        endcase
        return {(f == 8'd0), v, c, f};
    endfunction

    // Wide reference: whole-operand arithmetic/logic on w bits.
    task automatic ref_model(input int w, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic cin,
                             output logic [31:0] res, output logic c, output logic v,
                             output logic z);
        logic [63:0] mask, aa, bb, full;
        mask = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & mask;
        bb = {32'd0, (op == 3'd1) ? ~b : b} & mask;
        c = 1'b0; v = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                full = aa + bb + {63'd0, cin};
                c = full[w];
                v = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
            end
            3'd2: full = aa & bb;
            3'd3: full = aa | bb;
            3'd4: full = aa ^ bb;
            3'd5: full = aa;
            3'd6: full = bb;
            default: full = ~aa;
        endcase
        full = full & mask;
        res = full[31:0];
        z = (full == 64'd0);
    endtask

    function automatic logic exp_byte_cin(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin, input int k);
        logic [63:0] mk, bb, low;
        if (k == 0) return cin;
        if (op > 3'd1) return 1'b0;
        mk = (64'd1 << (8 * k)) - 64'd1;
        bb = {32'd0, (op == 3'd1) ? ~b : b};
        low = ({32'd0, a} & mk) + (bb & mk) + {63'd0, cin};
        return low[8*k];
    endfunction

    // ---------------- NBYTES=2 instance ----------------
    logic        c2_valid, c2_ready, c2_cin;
    logic [2:0]  c2_op;
    logic [15:0] c2_a, c2_b;
    logic        r2_valid, r2_ready, r2_carry, r2_ovf, r2_zero;
    logic [15:0] r2_result;
    logic        e2, i3_2, i4_2, i5_2, ci2, z2, co2, v2;
    logic [7:0]  ar2, as2, f2, fm2;

    assign {z2, v2, co2, fm2} = alu_byte({i5_2, i4_2, i3_2}, ar2, as2, ci2);
    assign f2 = e2 ? fm2 : 8'hA5;

    alu_seq_wide #(.NBYTES(2)) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_op(c2_op), .cmd_cin(c2_cin),
        .cmd_a(c2_a), .cmd_b(c2_b),
        .rsp_valid(r2_valid), .rsp_ready(r2_ready), .rsp_result(r2_result),
        .rsp_carry(r2_carry), .rsp_overflow(r2_ovf), .rsp_zero(r2_zero),
        .alu_en(e2), .alu_i3(i3_2), .alu_i4(i4_2), .alu_i5(i5_2), .alu_c_in(ci2),
        .alu_r(ar2), .alu_s(as2), .alu_f(f2),
        .alu_zero(z2), .alu_c_out(co2), .alu_overflow(v2)
    );

    // ---------------- NBYTES=1 instance ----------------
    logic        c1_valid, c1_ready, c1_cin;
    logic [2:0]  c1_op;
    logic [7:0]  c1_a, c1_b;
    logic        r1_valid, r1_ready, r1_carry, r1_ovf, r1_zero;
    logic [7:0]  r1_result;
    logic        e1, i3_1, i4_1, i5_1, ci1, z1, co1, v1;
    logic [7:0]  ar1, as1, f1, fm1;

    assign {z1, v1, co1, fm1} = alu_byte({i5_1, i4_1, i3_1}, ar1, as1, ci1);
    assign f1 = e1 ? fm1 : 8'hA5;

    alu_seq_wide #(.NBYTES(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_op(c1_op), .cmd_cin(c1_cin),
        .cmd_a(c1_a), .cmd_b(c1_b),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_result(r1_result),
        .rsp_carry(r1_carry), .rsp_overflow(r1_ovf), .rsp_zero(r1_zero),
        .alu_en(e1), .alu_i3(i3_1), .alu_i4(i4_1), .alu_i5(i5_1), .alu_c_in(ci1),
        .alu_r(ar1), .alu_s(as1), .alu_f(f1),
        .alu_zero(z1), .alu_c_out(co1), .alu_overflow(v1)
    );

    // Pending second command offered during backpressure (offer_next).
    logic [15:0] nx_a, nx_b;
    logic [2:0]  nx_op;
    logic        nx_cin;

    task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic cin, input int stall, input bit offer_next);
        int n, en_cnt;
        logic [31:0] er;
        logic ec, ev, ez;
        ref_model(16, op, 32'(a), 32'(b), cin, er, ec, ev, ez);
        n = 0;
        while (!c2_ready && n < 20) begin @(negedge clk); n++; end
        check("n2_cmd_ready", 32'(c2_ready), 32'd1);
        c2_valid = 1'b1; c2_a = a; c2_b = b; c2_op = op; c2_cin = cin;
        @(posedge clk);
        @(negedge clk);
        c2_valid = 1'b0;
        c2_a = 16'($urandom); c2_b = 16'($urandom); c2_op = 3'($urandom); c2_cin = 1'($urandom);
        en_cnt = 0; n = 1;
        while (!r2_valid && n <= 10) begin
            if (e2) begin
                check("n2_alu_r", 32'(ar2), (32'(a) >> (8 * en_cnt)) & 32'hFF);
                check("n2_alu_s", 32'(as2), (32'(b) >> (8 * en_cnt)) & 32'hFF);
                check("n2_alu_c_in", 32'(ci2), 32'(exp_byte_cin(op, 32'(a), 32'(b), cin, en_cnt)));
                check("n2_busy_ready", 32'(c2_ready), 32'd0);
                en_cnt++;
            end
            @(negedge clk); n++;
        end
        check("n2_latency", 32'(n), 32'd3);
        check("n2_en_cycles", 32'(en_cnt), 32'd2);
        check("n2_result", 32'(r2_result), er);
        check("n2_carry", 32'(r2_carry), 32'(ec));
        check("n2_overflow", 32'(r2_ovf), 32'(ev));
        check("n2_zero", 32'(r2_zero), 32'(ez));
        check("n2_done_en", 32'({e2, ar2, as2}), 32'd0);
        if (offer_next) begin
            c2_valid = 1'b1; c2_a = nx_a; c2_b = nx_b; c2_op = nx_op; c2_cin = nx_cin;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("n2_hold_valid", 32'(r2_valid), 32'd1);
            check("n2_hold_result", 32'(r2_result), er);
            check("n2_hold_flags", 32'({r2_carry, r2_ovf, r2_zero}), 32'({ec, ev, ez}));
            check("n2_hold_ready", 32'(c2_ready), 32'd0);
            check("n2_hold_en", 32'(e2), 32'd0);
        end
        r2_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r2_ready = 1'b0;
        check("n2_after_valid", 32'(r2_valid), 32'd0);
        check("n2_after_ready", 32'(c2_ready), 32'd1);
        check("n2_after_en", 32'(e2), 32'd0);
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic cin);
        int n, en_cnt;
        logic [31:0] er;
        logic ec, ev, ez;
        ref_model(8, op, 32'(a), 32'(b), cin, er, ec, ev, ez);
        n = 0;
        while (!c1_ready && n < 20) begin @(negedge clk); n++; end
        check("n1_cmd_ready", 32'(c1_ready), 32'd1);
        c1_valid = 1'b1; c1_a = a; c1_b = b; c1_op = op; c1_cin = cin;
        @(posedge clk);
        @(negedge clk);
        c1_valid = 1'b0; c1_a = 8'($urandom); c1_b = 8'($urandom);
        en_cnt = 0; n = 1;
        while (!r1_valid && n <= 10) begin
            if (e1) begin
                check("n1_alu_rs", 32'({ar1, as1}), 32'({a, b}));
                check("n1_alu_c_in", 32'(ci1), 32'(cin));
                en_cnt++;
            end
            @(negedge clk); n++;
        end
        check("n1_latency", 32'(n), 32'd2);
        check("n1_en_cycles", 32'(en_cnt), 32'd1);
        check("n1_result", 32'(r1_result), er);
        check("n1_flags", 32'({r1_carry, r1_ovf, r1_zero}), 32'({ec, ev, ez}));
        r1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r1_ready = 1'b0;
        check("n1_after_valid", 32'(r1_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        c2_valid = 1'b0; c2_a = '0; c2_b = '0; c2_op = '0; c2_cin = 1'b0; r2_ready = 1'b0;
        c1_valid = 1'b0; c1_a = '0; c1_b = '0; c1_op = '0; c1_cin = 1'b0; r1_ready = 1'b0;
        nx_a = '0; nx_b = '0; nx_op = '0; nx_cin = 1'b0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(c2_ready), 32'd1);
        check("rst_rsp_valid", 32'(r2_valid), 32'd0);
        check("rst_alu", 32'({e2, ar2, as2, ci2, i5_2, i4_2, i3_2}), 32'd0);
        check("rst_rsp", 32'({r2_result, r2_carry, r2_ovf, r2_zero}), 32'd0);
        check("rst_n1", 32'({c1_ready, r1_valid, e1}), 32'b100);
        reset = 1'b0;
        @(negedge clk);

        // Directed carry chain and all-zero result
        run2(16'h12FF, 16'h0001, 3'd0, 1'b0, 0, 1'b0);
        run2(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1, 1'b0);
        run2(16'h7FFF, 16'h0001, 3'd0, 1'b0, 0, 1'b0);

        // Backpressure with a second command held during the stall
        nx_a = 16'h1234; nx_b = 16'h0F0F; nx_op = 3'd1; nx_cin = 1'b1;
        run2(16'h8000, 16'h8000, 3'd0, 1'b0, 5, 1'b1);
        check("bp_second_pending", 32'(c2_valid), 32'd1);
        run2(nx_a, nx_b, nx_op, nx_cin, 0, 1'b0);

        // Reset mid-EXEC aborts the command
        c2_valid = 1'b1; c2_a = 16'hABCD; c2_b = 16'h1111; c2_op = 3'd0; c2_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        c2_valid = 1'b0;
        check("abort_en_before", 32'(e2), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_alu", 32'({e2, ar2, as2, ci2}), 32'd0);
        check("abort_cmd_ready", 32'(c2_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'({r2_valid, e2}), 32'd0);
        end

        // Randomized commands with random backpressure
        for (int i = 0; i < 40; i++)
            run2(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
                 int'($urandom_range(0, 3)), 1'b0);

        // Single-byte configuration
        run1(8'h7F, 8'h01, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            run1(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
